// File: rtl/match_scoreboard.sv
// N-player match score keeper: edge-detected goal counting, post-goal freeze,
// winner latch at WIN_SCORE and restart handling. All outputs are registered.
module match_scoreboard #(
    parameter int NUM_PLAYERS = 2,
    parameter int SCORE_W     = 4,
    parameter int WIN_SCORE   = 9,
    parameter int HOLD_CYCLES = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_PLAYERS-1:0]         goal,
    input  logic                           restart,
    output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
    output logic [NUM_PLAYERS-1:0]         score_event,
    output logic                           goal_hold,
    output logic                           game_over,
    output logic [NUM_PLAYERS-1:0]         winner
);

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   HOLD_LOAD = (HOLD_CYCLES > 0) ? CNT_W'(HOLD_CYCLES - 1) : '0;
    localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);

    typedef enum logic [1:0] {
        ST_PLAY,
        ST_HOLD,
        ST_OVER
    } state_t;

    state_t                           state_q, state_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic [NUM_PLAYERS-1:0]           goal_q, goal_d;
    logic [NUM_PLAYERS*SCORE_W-1:0]   scores_q, scores_d;
    logic [NUM_PLAYERS-1:0]           score_event_q, score_event_d;
    logic                             goal_hold_q, goal_hold_d;
    logic                             game_over_q, game_over_d;
    logic [NUM_PLAYERS-1:0]           winner_q, winner_d;

    logic [NUM_PLAYERS-1:0]           rise;
    logic [NUM_PLAYERS-1:0]           win_mask;
    logic [NUM_PLAYERS*SCORE_W-1:0]   inc_scores;

    // Candidate scores if every riser were credited; saturates at WIN_SCORE.
    always_comb begin
        rise       = goal & ~goal_q;
        goal_d     = goal;
        inc_scores = scores_q;
        win_mask   = '0;
        for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
            if (rise[i] && (scores_q[i*SCORE_W +: SCORE_W] != WIN_VAL)) begin
                inc_scores[i*SCORE_W +: SCORE_W] = scores_q[i*SCORE_W +: SCORE_W] + SCORE_W'(1);
            end
            win_mask[i] = rise[i] && (inc_scores[i*SCORE_W +: SCORE_W] == WIN_VAL);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_PLAY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (restart) begin
            state_d = ST_PLAY;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_PLAY: begin
                    if (|rise) begin
                        if (|win_mask) begin
                            state_d = ST_OVER;
                        end else if (HOLD_CYCLES > 0) begin
                            state_d = ST_HOLD;
                            cnt_d   = HOLD_LOAD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == '0) begin
                        state_d = ST_PLAY;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_OVER: state_d = ST_OVER;
                default: state_d = ST_PLAY;
            endcase
        end
    end

    // Flags follow the next state so they line up with the state register.
    always_comb begin
        scores_d      = scores_q;
        score_event_d = '0;
        winner_d      = winner_q;
        goal_hold_d   = (state_d == ST_HOLD);
        game_over_d   = (state_d == ST_OVER);
        if (restart) begin
            scores_d = '0;
            winner_d = '0;
        end else if ((state_q == ST_PLAY) && (|rise)) begin
            scores_d      = inc_scores;
            score_event_d = rise;
            if (|win_mask) begin
                winner_d = win_mask;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q         <= '0;
            goal_q        <= '1;
            scores_q      <= '0;
            score_event_q <= '0;
            goal_hold_q   <= 1'b0;
            game_over_q   <= 1'b0;
            winner_q      <= '0;
        end else begin
            cnt_q         <= cnt_d;
            goal_q        <= goal_d;
            scores_q      <= scores_d;
            score_event_q <= score_event_d;
            goal_hold_q   <= goal_hold_d;
            game_over_q   <= game_over_d;
            winner_q      <= winner_d;
        end
    end

    assign scores      = scores_q;
    assign score_event = score_event_q;
    assign goal_hold   = goal_hold_q;
    assign game_over   = game_over_q;
    assign winner      = winner_q;

endmodule

// File: tb/tb_match_scoreboard.sv
// Bench for match_scoreboard: cycle model feeding an expectation queue for the
// default instance, plus directed checks and a 3-player no-freeze instance.
module tb_match_scoreboard;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] goal = '0;
    logic       restart = 1'b0;
    logic [7:0] scores;
    logic [1:0] score_event;
    logic       goal_hold;
    logic       game_over;
    logic [1:0] winner;

    logic        reset3 = 1'b0;
    logic [2:0]  goal3 = '0;
    logic        restart3 = 1'b0;
    logic [11:0] scores3;
    logic [2:0]  score_event3;
    logic        goal_hold3;
    logic        game_over3;
    logic [2:0]  winner3;
    logic        hold3_seen = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    match_scoreboard dut (
        .clk(clk), .reset(reset), .goal(goal), .restart(restart),
        .scores(scores), .score_event(score_event), .goal_hold(goal_hold),
        .game_over(game_over), .winner(winner)
    );

    match_scoreboard #(
        .NUM_PLAYERS(3), .SCORE_W(4), .WIN_SCORE(3), .HOLD_CYCLES(0)
    ) dut3 (
        .clk(clk), .reset(reset3), .goal(goal3), .restart(restart3),
        .scores(scores3), .score_event(score_event3), .goal_hold(goal_hold3),
        .game_over(game_over3), .winner(winner3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [7:0] scores;
        logic [1:0] ev;
        logic       hold;
        logic       over;
        logic [1:0] win;
    } exp_t;

    exp_t sb_q[$];

    // Reference model of the default instance (2 players, win 9, freeze 16).
    int         m_score[2];
    int         m_cnt;
    int         m_state;
    logic [1:0] m_gq, m_ev, m_win;
    logic       m_hold, m_over;

    always @(posedge clk or posedge reset) begin
        logic [1:0] r;
        logic [1:0] wm;
        exp_t e;
        if (reset) begin
            m_score[0] = 0; m_score[1] = 0;
            m_cnt = 0; m_state = 0; m_gq = 2'b11;
            m_ev = '0; m_win = '0; m_hold = 0; m_over = 0;
            sb_q.delete();
        end else begin
            r    = goal & ~m_gq;
            m_gq = goal;
            m_ev = '0;
            if (restart) begin
                m_score[0] = 0; m_score[1] = 0;
                m_win = '0; m_hold = 0; m_over = 0; m_state = 0; m_cnt = 0;
            end else if (m_state == 0) begin
                if (r != 0) begin
                    wm = '0;
                    for (int i = 0; i < 2; i++) begin
                        if (r[i]) m_score[i] = m_score[i] + 1;
                        if (r[i] && m_score[i] == 9) wm[i] = 1'b1;
                    end
                    m_ev = r;
                    if (wm != 0) begin
                        m_state = 2; m_over = 1; m_win = wm;
                    end else begin
                        m_state = 1; m_cnt = 15; m_hold = 1;
                    end
                end
            end else if (m_state == 1) begin
                if (m_cnt == 0) begin
                    m_state = 0; m_hold = 0;
                end else begin
                    m_cnt = m_cnt - 1;
                end
            end
            e.scores = {4'(m_score[1]), 4'(m_score[0])};
            e.ev     = m_ev;
            e.hold   = m_hold;
            e.over   = m_over;
            e.win    = m_win;
            sb_q.push_back(e);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("sb_scores", 32'(scores), 32'(e.scores));
            check("sb_event", 32'(score_event), 32'(e.ev));
            check("sb_hold", 32'(goal_hold), 32'(e.hold));
            check("sb_over", 32'(game_over), 32'(e.over));
            check("sb_winner", 32'(winner), 32'(e.win));
        end
        if (goal_hold3) hold3_seen = 1'b1;
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Single rising pulse on goal[p], then wait out any freeze.
    task automatic pulse(input int p);
        @(negedge clk);
        goal[p] = 1'b1;
        @(negedge clk);
        goal[p] = 1'b0;
        for (int k = 0; k < 40 && goal_hold; k++) @(negedge clk);
        check("hold_end", 32'(goal_hold), 32'd0);
    endtask

    initial begin
        int hc;
        #1;
        reset  = 1'b1;
        reset3 = 1'b1;
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        reset3 = 1'b0;
        check("rst_scores", 32'(scores), 32'd0);
        check("rst_flags", 32'({score_event, goal_hold, game_over, winner}), 32'd0);

        // 1: single goal, event pulse, freeze length
        @(negedge clk); goal = 2'b01;
        @(negedge clk); goal = 2'b00;
        check("t1_p0", 32'(scores), 32'h01);
        check("t1_event", 32'(score_event), 32'd1);
        hc = 0;
        for (int k = 0; k < 40; k++) begin
            if (goal_hold) hc++;
            @(negedge clk);
        end
        check("t1_hold_len", 32'(hc), 32'd16);

        // 2: held goal counts once; rise during freeze ignored
        goal = 2'b10;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 4) goal[0] = 1'b1;
            if (k == 6) goal[0] = 1'b0;
        end
        goal = 2'b00;
        @(negedge clk);
        check("t2_scores", 32'(scores), 32'h11);

        // 3: simultaneous winning goals from 8-8 -> draw
        for (int k = 0; k < 7; k++) pulse(0);
        for (int k = 0; k < 7; k++) pulse(1);
        check("t3_88", 32'(scores), 32'h88);
        @(negedge clk); goal = 2'b11;
        @(negedge clk); goal = 2'b00;
        check("t3_scores", 32'(scores), 32'h99);
        check("t3_over", 32'(game_over), 32'd1);
        check("t3_winner", 32'(winner), 32'd3);
        check("t3_hold", 32'(goal_hold), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); goal = 2'b11;
            @(negedge clk); goal = 2'b00;
        end
        check("t3_frozen", 32'(scores), 32'h99);

        // 4: restart from 9-3 with goal[0] high that cycle
        do_reset();
        for (int k = 0; k < 3; k++) pulse(1);
        for (int k = 0; k < 9; k++) pulse(0);
        check("t4_93", 32'(scores), 32'h39);
        check("t4_over", 32'(game_over), 32'd1);
        @(negedge clk); goal = 2'b01; restart = 1'b1;
        @(negedge clk); restart = 1'b0;
        check("t4_scores", 32'(scores), 32'd0);
        check("t4_clear", 32'({winner, game_over}), 32'd0);
        repeat (3) @(negedge clk);
        check("t4_no_credit", 32'(scores), 32'd0);
        goal = 2'b00;
        @(negedge clk); goal = 2'b01;
        @(negedge clk); goal = 2'b00;
        check("t4_recredit", 32'(scores), 32'h01);
        for (int k = 0; k < 40 && goal_hold; k++) @(negedge clk);

        // 5: goal held across reset release, then async reset mid-freeze
        @(negedge clk); goal = 2'b01; reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_no_count", 32'(scores), 32'd0);
        goal = 2'b00;
        @(negedge clk); goal = 2'b01;
        @(negedge clk); goal = 2'b00;
        repeat (3) @(negedge clk);
        check("t5_in_hold", 32'(goal_hold), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("t5_async_scores", 32'(scores), 32'd0);
        check("t5_async_hold", 32'(goal_hold), 32'd0);
        @(negedge clk); reset = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_after", 32'({scores, goal_hold}), 32'd0);

        // 6: 3 players, no freeze, win at 3
        for (int r = 0; r < 3; r++) begin
            @(negedge clk); goal3 = 3'b100;
            @(negedge clk); goal3 = 3'b000;
            check("t6_p2", 32'(scores3), 32'((r + 1) << 8));
            check("t6_event", 32'(score_event3), 32'd4);
        end
        @(negedge clk);
        check("t6_winner", 32'(winner3), 32'd4);
        check("t6_over", 32'(game_over3), 32'd1);
        check("t6_hold_never", 32'(hold3_seen), 32'd0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
